result_arbiter_rr: RTL

RESULT_ARBITER_RR -- requirements
Module: result_arbiter_rr

---
 rtl/arb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 38 +++
 rtl/result_arbiter_rr.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Shared types and constants for the result arbiter slice.
//   - state_t : arbiter FSM state (IDLE, BUSY)
//   - N_REQ   : number of requesters
//   - SEL_W   : width of a requester index
//   - DATA_W  : width of one requester's result
//   - next_ptr: round-robin successor of an index, wrapping N_REQ-1 -> 0
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DATA_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // N_REQ is a power of two, so the natural SEL_W-bit wrap is the modulo.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] sel);
    return sel + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational rotate-priority encoder. Returns the first set request bit
//   at or after ptr, searching upward and wrapping N_REQ-1 -> 0.
//   Ports:
//     req [N_REQ-1:0] in  : request vector
//     ptr [SEL_W-1:0] in  : index with highest priority this round
//     idx [SEL_W-1:0] out : selected requester (0 when any is low)
//     any             out : at least one request is pending
// -----------------------------------------------------------------------------
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] pos;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = ptr + SEL_W'(k);
      if (!found && req[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/result_arbiter_rr.sv
// -----------------------------------------------------------------------------
// result_arbiter_rr
//   Round-robin arbiter that forwards one requester's 2-bit result at a time
//   to a single consumer through a registered valid/ready offer.
//   Parameters:
//     TIMEOUT : stall cycles tolerated before an offer is abandoned (0 = never)
//   Ports:
//     clk         in  : system clock, rising edge
//     rst         in  : asynchronous active-high reset
//     req[7:0]    in  : per-requester request, held until acknowledged
//     req_data    in  : packed results, requester i at [2i+1:2i]
//     out_ready   in  : consumer accepts the offered result this cycle
//     out_valid   out : out_data/out_sel hold an offered result
//     out_data    out : granted requester's result
//     out_sel     out : granted requester index
//     gnt[7:0]    out : one-hot acknowledge, only in the transfer cycle
//     timeout_err out : one-cycle pulse when an offer is abandoned
//   Configuration:
//     ARB_PRIO0_EN : requester 0 always wins in IDLE, and a requester-0
//                    release leaves the round-robin pointer unchanged.
// -----------------------------------------------------------------------------
module result_arbiter_rr
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic [N_REQ-1:0]        gnt,
  output logic                    timeout_err
);

  localparam int unsigned CNT_W  = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic        TMO_EN = (TIMEOUT != 0);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_sel_q, out_sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [SEL_W-1:0]    rr_idx;
  logic                rr_any;
  logic [SEL_W-1:0]    pick_idx;
  logic [DATA_W-1:0]   pick_data;
  logic [SEL_W-1:0]    release_ptr;
  logic                xfer;
  logic                tmo;
  logic [N_REQ-1:0]    gnt_vec;

  rr_pick u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (rr_idx),
    .any (rr_any)
  );

  // Priority override sits outside the encoder so rr_pick stays pure RR.
  always_comb begin
    pick_idx = rr_idx;
`ifdef ARB_PRIO0_EN
    if (req[0]) begin
      pick_idx = '0;
    end
`endif
  end

  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (SEL_W'(i) == pick_idx) begin
        pick_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    release_ptr = next_ptr(out_sel_q);
`ifdef ARB_PRIO0_EN
    if (out_sel_q == '0) begin
      release_ptr = ptr_q;
    end
`endif
  end

  // Acknowledge and timeout depend on this cycle's out_ready, so they are
  // decoded from registered state rather than registered themselves.
  // A ready consumer always beats the timeout in the same cycle.
  assign xfer = (state_q == BUSY) && out_ready;
  assign tmo  = (state_q == BUSY) && !out_ready && TMO_EN && (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    gnt_vec           = '0;
    gnt_vec[out_sel_q] = xfer;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (rr_any) begin
          out_sel_d   = pick_idx;
          out_data_d  = pick_data;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (xfer || tmo) begin
          out_valid_d = 1'b0;
          ptr_d       = release_ptr;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_sel     = out_sel_q;
  assign gnt         = gnt_vec;
  assign timeout_err = tmo;

endmodule
